div_unit: RTL and testbench
===========================

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving operand and result width.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1: a valid M-extension divide/remainder op occupies EX; held stable while ex_stall=1.
REQ-005 The block SHALL have port op, input, 2: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-006 The block SHALL have port dividend, input, XLEN: rs1 operand (forwarded value).
REQ-007 The block SHALL have port divisor, input, XLEN: rs2 operand (forwarded value).
REQ-008 The block SHALL have port flush, input, 1: abort the in-flight operation (trap/redirect).
REQ-009 The block SHALL have port ex_stall, output, 1: freeze the whole pipeline; feeds the hazard unit stall input.
REQ-010 The block SHALL have port result, output, XLEN: quotient or remainder per latched op.
REQ-011 The block SHALL have port result_valid, output, 1: result is valid this cycle.
REQ-012 The block SHALL have port busy, output, 1: state is BUSY.

Function
REQ-013 The FSM SHALL have states IDLE, BUSY, DONE.
REQ-014 In IDLE, with start=1 and flush=0, the block SHALL latch op, operands, |dividend|, |divisor|, quotient sign (dividend[XLEN-1]^divisor[XLEN-1], signed ops only) and remainder sign (dividend[XLEN-1], signed ops only).
REQ-015 On that accept, if divisor==0 or (signed op and dividend==100..0 and divisor==all ones), the block SHALL go IDLE->DONE; otherwise it SHALL go IDLE->BUSY with iteration counter = XLEN-1.
REQ-016 In BUSY, each cycle SHALL perform one restoring-division step: shift {rem,quo} left by 1, trial-subtract the divisor, and set the quotient bit if the result is non-negative; arithmetic SHALL be XLEN+1 bits wide.
REQ-017 In BUSY, when counter==0 the step SHALL complete and the state SHALL go to DONE; otherwise the counter SHALL decrement.
REQ-018 DONE SHALL go to IDLE unconditionally after one cycle; start remaining high in DONE SHALL NOT restart the unit.
REQ-019 ex_stall SHALL equal (state==IDLE && start && !flush) || state==BUSY, combinationally; it SHALL be 0 in DONE.
REQ-020 Latency: a normal op SHALL stall cycles 0..XLEN (XLEN+1 cycles), with DONE and result_valid in cycle XLEN+1; a special-case op SHALL stall cycle 0 only, with DONE in cycle 1.
REQ-021 result_valid SHALL be 1 only in DONE; result SHALL be registered and 0 when result_valid=0.
REQ-022 A signed quotient SHALL be negated when the quotient sign=1, and a signed remainder negated when the remainder sign=1.
REQ-023 Divide-by-zero SHALL return quotient all ones (DIV and DIVU) and remainder = original dividend.
REQ-024 Signed overflow SHALL return quotient = 100..0 and remainder = 0.
REQ-025 flush=1 in any state SHALL force the next state to IDLE, drive ex_stall=0 and result_valid=0 in that cycle, and discard partial results.
REQ-026 A back-to-back divide SHALL be accepted in the IDLE cycle following DONE, with no lost or duplicated ops.

Reset
REQ-027 rst=1 SHALL immediately force state IDLE and counter 0, and set ex_stall, busy, result_valid and result to 0, including mid-BUSY.
REQ-028 After rst deasserts, the first edge with start=1 SHALL be treated as a fresh accept.

Verification
REQ-029 DIVU 100/7: start held -> ex_stall high 33 cycles, then result_valid with result=14; REMU gives 2.
REQ-030 DIV -7/2 -> quotient 0xFFFFFFFD (-3); REM -7/2 -> remainder 0xFFFFFFFF (-1).
REQ-031 DIV 5/0 -> DONE at cycle 1, quotient 0xFFFFFFFF; REM 5/0 -> 5; ex_stall high exactly 1 cycle.
REQ-032 DIV 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, REM -> 0, with 1-cycle stall.
REQ-033 flush at BUSY cycle 10 -> ex_stall low the same cycle, IDLE next cycle, no result_valid; a following DIVU 9/3 returns 3.
REQ-034 rst pulsed at BUSY cycle 20 -> all outputs 0 asynchronously; a following DIVU 0xFFFFFFFF/1 returns 0xFFFFFFFF after a full 33-cycle stall.

Source files
------------

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module   : div_unit
// Brief    : Iterative radix-2 restoring divider for RV M-extension DIV/DIVU/REM/REMU.
// Revision : 1.0 - initial release
// ============================================================================
module div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            flush,
    output logic            ex_stall,
    output logic [XLEN-1:0] result,
    output logic            result_valid,
    output logic            busy
);

    localparam int c_CW = (XLEN > 1) ? $clog2(XLEN) : 1;
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;
    localparam logic [XLEN-1:0] c_MIN = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]      r_state;
    logic [c_CW-1:0] r_cnt;
    logic            r_rem_op;
    logic            r_q_neg;
    logic            r_r_neg;
    logic [XLEN-1:0] r_dvs;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_result;

    // Operand preparation for the accept cycle
    logic            w_signed;
    logic            w_dvd_neg;
    logic            w_dvs_neg;
    logic [XLEN-1:0] w_dvd_abs;
    logic [XLEN-1:0] w_dvs_abs;
    logic            w_div_zero;
    logic            w_ovf;
    logic [XLEN-1:0] w_special_res;

    assign w_signed      = ~op[0];
    assign w_dvd_neg     = w_signed & dividend[XLEN-1];
    assign w_dvs_neg     = w_signed & divisor[XLEN-1];
    assign w_dvd_abs     = w_dvd_neg ? -dividend : dividend;
    assign w_dvs_abs     = w_dvs_neg ? -divisor : divisor;
    assign w_div_zero    = (divisor == '0);
    assign w_ovf         = w_signed && (dividend == c_MIN) && (divisor == '1);
    assign w_special_res = w_div_zero ? (op[1] ? dividend : '1)
                                      : (op[1] ? '0 : c_MIN);

    // One restoring step: remainder stays below divisor, so the restored value fits XLEN bits
    logic [XLEN:0]   w_shift;
    logic [XLEN:0]   w_diff;
    logic            w_ge;
    logic [XLEN-1:0] w_rem_nx;
    logic [XLEN-1:0] w_quo_nx;
    logic [XLEN-1:0] w_final;

    assign w_shift  = {r_rem, r_quo[XLEN-1]};
    assign w_diff   = w_shift - {1'b0, r_dvs};
    assign w_ge     = ~w_diff[XLEN];
    assign w_rem_nx = w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
    assign w_quo_nx = {r_quo[XLEN-2:0], w_ge};
    assign w_final  = r_rem_op ? (r_r_neg ? -w_rem_nx : w_rem_nx)
                               : (r_q_neg ? -w_quo_nx : w_quo_nx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_cnt    <= '0;
            r_rem_op <= 1'b0;
            r_q_neg  <= 1'b0;
            r_r_neg  <= 1'b0;
            r_dvs    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_result <= '0;
        end else if (flush) begin
            r_state  <= c_IDLE;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_rem_op <= op[1];
                        r_q_neg  <= w_dvd_neg ^ w_dvs_neg;
                        r_r_neg  <= w_dvd_neg;
                        r_dvs    <= w_dvs_abs;
                        r_rem    <= '0;
                        r_quo    <= w_dvd_abs;
                        if (w_div_zero || w_ovf) begin
                            r_state  <= c_DONE;
                            r_result <= w_special_res;
                        end else begin
                            r_state <= c_BUSY;
                            r_cnt   <= c_CW'(XLEN - 1);
                        end
                    end
                end
                c_BUSY: begin
                    r_rem <= w_rem_nx;
                    r_quo <= w_quo_nx;
                    if (r_cnt == '0) begin
                        r_state  <= c_DONE;
                        r_result <= w_final;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                c_DONE: begin
                    r_state  <= c_IDLE;
                    r_result <= '0;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign busy         = (r_state == c_BUSY);
    assign ex_stall     = !flush && (((r_state == c_IDLE) && start) || busy);
    assign result_valid = (r_state == c_DONE) && !flush;
    assign result       = result_valid ? r_result : '0;

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_unit
// Brief    : Scoreboard bench for div_unit with directed divide/remainder vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_unit;

    localparam logic [1:0] c_DIV  = 2'b00;
    localparam logic [1:0] c_DIVU = 2'b01;
    localparam logic [1:0] c_REM  = 2'b10;
    localparam logic [1:0] c_REMU = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        flush = 1'b0;
    logic        ex_stall;
    logic [31:0] result;
    logic        result_valid;
    logic        busy;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    div_unit #(.XLEN(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .op           (op),
        .dividend     (dividend),
        .divisor      (divisor),
        .flush        (flush),
        .ex_stall     (ex_stall),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one op, hold start while stalled, and check the stall length
    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_stall);
        int n;
        @(negedge clk);
        exp_q.push_back(exp_res);
        op = o;
        dividend = a;
        divisor = b;
        start = 1'b1;
        #1;
        n = 0;
        while (ex_stall && n < 100) begin
            n++;
            @(negedge clk);
            #1;
        end
        start = 1'b0;
        chk({name, " stall"}, 32'(n), 32'(exp_stall));
    endtask

    // Monitor: compare every presented result against the scoreboard head
    always @(negedge clk) begin
        #2;
        if (!rst && result_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result: got 0x%08h expected no result_valid", result);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (result !== e) begin
                    errors++;
                    $display("FAIL result: got 0x%08h expected 0x%08h", result, e);
                end
            end
        end
    end

    initial begin
        #1;
        chk("reset ex_stall", {31'b0, ex_stall}, 32'd0);
        chk("reset busy", {31'b0, busy}, 32'd0);
        chk("reset result_valid", {31'b0, result_valid}, 32'd0);
        chk("reset result", result, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_op("divu_100_7", c_DIVU, 32'd100, 32'd7, 32'd14, 33);
        run_op("remu_100_7", c_REMU, 32'd100, 32'd7, 32'd2, 33);
        run_op("div_m7_2", c_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        run_op("rem_m7_2", c_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        run_op("div_7_m2", c_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
        run_op("rem_7_m2", c_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);
        run_op("remu_m7_2", c_REMU, 32'hFFFF_FFF9, 32'd2, 32'd1, 33);
        run_op("div_20_4", c_DIV, 32'd20, 32'd4, 32'd5, 33);
        run_op("remu_0_3", c_REMU, 32'd0, 32'd3, 32'd0, 33);
        run_op("div_5_0", c_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("rem_5_0", c_REM, 32'd5, 32'd0, 32'd5, 1);
        run_op("divu_5_0", c_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("div_ovf", c_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_ovf", c_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
        run_op("divu_no_ovf", c_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33);

        // Flush in BUSY cycle 10
        @(negedge clk);
        op = c_DIVU;
        dividend = 32'h1234_5678;
        divisor = 32'd3;
        start = 1'b1;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        start = 1'b0;
        #1;
        chk("flush ex_stall", {31'b0, ex_stall}, 32'd0);
        chk("flush result_valid", {31'b0, result_valid}, 32'd0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("post_flush busy", {31'b0, busy}, 32'd0);
        chk("post_flush ex_stall", {31'b0, ex_stall}, 32'd0);
        run_op("divu_9_3", c_DIVU, 32'd9, 32'd3, 32'd3, 33);

        // Asynchronous reset in BUSY cycle 20
        @(negedge clk);
        op = c_DIV;
        dividend = 32'd1000;
        divisor = 32'd7;
        start = 1'b1;
        repeat (20) @(negedge clk);
        #3;
        rst = 1'b1;
        start = 1'b0;
        #1;
        chk("rst ex_stall", {31'b0, ex_stall}, 32'd0);
        chk("rst busy", {31'b0, busy}, 32'd0);
        chk("rst result_valid", {31'b0, result_valid}, 32'd0);
        chk("rst result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op("divu_max_1", c_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
